axi_slv_rd_ctrl: RTL and testbench
==================================

Name: axi_slv_rd_ctrl

Overview:
- AXI4 read-channel responder (AR + R) in front of a single-port synchronous SRAM; instruction or data memory.
- Serves the rvseed IFU fetch master and any other AXI read master on the interconnect.
- Accepts one burst at a time, generates per-beat SRAM reads and returns R beats with RID echo, RRESP and RLAST.

Parameters:
- BASE_ADDR, `INST_MEM_BASE_ADDR: byte address of SRAM word 0.
- MEM_AW, 12: SRAM word-address width. Memory is 4*2^MEM_AW bytes.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- axi_slv_arvalid  in  1  AR valid
- axi_slv_arready  out  1  AR ready
- axi_slv_arid  in  `AXI_ID_WIDTH  transaction ID
- axi_slv_araddr  in  `AXI_ADDR_WIDTH  start byte address
- axi_slv_arlen  in  `AXI_LEN_WIDTH  beats minus 1
- axi_slv_arsize  in  `AXI_SIZE_WIDTH  bytes per beat = 2^arsize, max 4
- axi_slv_arburst  in  `AXI_BURST_WIDTH  FIXED/INCR/WRAP
- axi_slv_rvalid  out  1  R valid
- axi_slv_rready  in  1  R ready
- axi_slv_rid  out  `AXI_ID_WIDTH  latched arid
- axi_slv_rdata  out  `AXI_DATA_WIDTH  read word
- axi_slv_rresp  out  `AXI_RESP_WIDTH  OKAY or SLVERR
- axi_slv_rlast  out  1  final beat
- mem_rd_en  out  1  SRAM read strobe
- mem_rd_addr  out  MEM_AW  SRAM word address
- mem_rd_data  in  `AXI_DATA_WIDTH  SRAM data, valid 1 cycle after mem_rd_en

Behaviour:
- Reset, asynchronous, rst_n low: state IDLE; arready, rvalid, rlast, mem_rd_en = 0; rid, rdata, rresp, mem_rd_addr = 0.
- FSM states: IDLE, RD, RESP.
- IDLE:
  - arready is registered; it rises on the first clk edge after reset release.
  - On arvalid & arready, latch id, addr, len, size and burst, clear the beat counter, drop arready, go to RD.
- RD:
  - Drive mem_rd_en=1 and mem_rd_addr=(cur_addr-BASE_ADDR)>>2 for one cycle, then go to RESP.
  - rdata is captured from mem_rd_data on entry to RESP.
- RESP:
  - rvalid=1. rdata, rresp and rlast are held stable until rready.
  - rlast = (beat_cnt == len).
  - On rvalid & rready with a non-last beat: advance the address, increment beat_cnt, go to RD.
  - On the last beat: go to IDLE and reassert arready the next cycle.
- Latency and throughput:
  - First rvalid occurs 2 cycles after the AR handshake edge.
  - One beat per 2 cycles when rready is held high.
- Address generation, step = 2^size:
  - FIXED: address unchanged.
  - INCR: addr + step.
  - WRAP: len must be 1, 3, 7 or 15. Boundary is (len+1)*step. The next address wraps to the aligned base when it crosses the boundary.
  - Reserved burst 2'b11 is treated as INCR, with rresp=SLVERR on every beat.
- Data and size:
  - rdata is always the full aligned 32-bit word.
  - Narrow sizes step sub-word, so consecutive beats can return the same word.
  - arsize > 2 returns SLVERR on all beats. The address is still stepped by 4.
- ID and response:
  - rid equals the latched arid for every beat.
  - rresp is OKAY unless an error rule applies.
- rvalid never drops without an rready handshake.
- No new AR is accepted while a burst is in flight.
- len=0: a single beat with rlast=1.
- len=255: 256 beats. The beat counter is 8 bits and never wraps mid-burst.
- Reset asserted mid-burst aborts immediately to IDLE with all outputs at their reset values. No residual beat is issued.

Optional Feature:
- Macro: AXI_SLV_RD_ADDR_CHK_EN.
- Defined: each beat's address is checked against [BASE_ADDR, BASE_ADDR+4*2^MEM_AW).
  - An out-of-range beat suppresses mem_rd_en, returns rdata=0 and rresp=SLVERR. RD still takes one cycle.
  - In-range beats of the same burst return OKAY.
- Undefined: no check. The word address is truncated to MEM_AW bits, aliasing modulo the memory size, and rresp is always OKAY apart from the burst/size errors above.

Decomposition:
- Shared AXI define file holds `AXI_*_WIDTH, `AXI_BURTS_INCR/FIXED/WRAP, `AXI_SIZE_* and `AXI_RESP_OKAY/SLVERR. Add any missing codes there.
- FSM state encodings are local parameters.
- One sub-module: axi_burst_addr_gen. It is combinational: current addr, size, len and burst in; next addr out. It is reusable by the write-side slave.

Test Plan:
- Single beat: AR addr=BASE+0x10, len=0, INCR, size=2, id=3; SRAM word 4=0xDEADBEEF; rready=1 → rvalid 2 cycles after AR with rdata=0xDEADBEEF, rid=3, rlast=1, rresp=OKAY; arready returns next cycle.
- INCR burst: addr=BASE, len=3, rready toggled 1/0 → four beats of words 0..3 in order, each held across stalls; rlast only on beat 4.
- WRAP: addr=BASE+0x08, len=3, size=2 → words 2, 3, 0, 1; FIXED with len=2 → word 2 three times.
- Error (macro defined): addr=BASE+4*2^MEM_AW-4, INCR, len=1 → beat 0 OKAY with data, beat 1 SLVERR with rdata=0 and no mem_rd_en; arsize=3 → all beats SLVERR.
- Back-to-back: arvalid held high with a second AR queued → second AR accepted only the cycle after the first burst's rlast handshake; rid switches accordingly.
- Reset mid-burst: rst_n low during beat 2 of len=7 → rvalid=0 and arready=0 immediately; after release, arready=1 and a fresh burst completes correctly.

Source files
------------

// File: rtl/axi_slv_rd_ctrl_pkg.sv
// Shared AXI field widths/codes plus types and helpers for the SRAM read-channel slave.
// Optional build macro AXI_SLV_RD_ADDR_CHK_EN enables per-beat address window checking.
`ifndef AXI_DEFINES_SV
`define AXI_DEFINES_SV
`define AXI_ID_WIDTH       4
`define AXI_ADDR_WIDTH     32
`define AXI_LEN_WIDTH      8
`define AXI_SIZE_WIDTH     3
`define AXI_BURST_WIDTH    2
`define AXI_DATA_WIDTH     32
`define AXI_RESP_WIDTH     2
`define AXI_BURTS_FIXED    2'b00
`define AXI_BURTS_INCR     2'b01
`define AXI_BURTS_WRAP     2'b10
`define AXI_BURTS_RSVD     2'b11
`define AXI_SIZE_1B        3'b000
`define AXI_SIZE_2B        3'b001
`define AXI_SIZE_4B        3'b010
`define AXI_RESP_OKAY      2'b00
`define AXI_RESP_SLVERR    2'b10
`define INST_MEM_BASE_ADDR 32'h8000_0000
`endif

package axi_slv_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } rd_state_e;

  // Oversized beats still advance by one full word.
  function automatic logic [`AXI_ADDR_WIDTH-1:0] beat_step(input logic [`AXI_SIZE_WIDTH-1:0] size);
    if (size > `AXI_SIZE_4B) return `AXI_ADDR_WIDTH'(4);
    return `AXI_ADDR_WIDTH'(1) << size;
  endfunction

  function automatic logic in_window(input logic [`AXI_ADDR_WIDTH-1:0] addr,
                                     input logic [`AXI_ADDR_WIDTH-1:0] base,
                                     input int unsigned                aw);
    return (addr >= base) && (((addr - base) >> (aw + 2)) == '0);
  endfunction

endpackage

// File: rtl/axi_slv_rd_ctrl_addr_gen.sv
// Combinational AXI burst next-address generator (FIXED / INCR / WRAP); shared with the write slave.
module axi_burst_addr_gen
  import axi_slv_rd_ctrl_pkg::*;
(
  input  logic [`AXI_ADDR_WIDTH-1:0]  addr_i,
  input  logic [`AXI_SIZE_WIDTH-1:0]  size_i,
  input  logic [`AXI_LEN_WIDTH-1:0]   len_i,
  input  logic [`AXI_BURST_WIDTH-1:0] burst_i,
  output logic [`AXI_ADDR_WIDTH-1:0]  next_addr_o
);

  logic [`AXI_ADDR_WIDTH-1:0] step;
  logic [`AXI_ADDR_WIDTH-1:0] wrap_mask;
  logic [`AXI_ADDR_WIDTH-1:0] incr_addr;

  always_comb begin
    step      = beat_step(size_i);
    wrap_mask = ((`AXI_ADDR_WIDTH'(len_i) + 1'b1) * step) - 1'b1;
    incr_addr = addr_i + step;
    case (burst_i)
      `AXI_BURTS_FIXED: next_addr_o = addr_i;
      // Landing exactly on the boundary means we stepped past the wrap window.
      `AXI_BURTS_WRAP:  next_addr_o = ((incr_addr & wrap_mask) == '0) ? (addr_i & ~wrap_mask)
                                                                       : incr_addr;
      default:          next_addr_o = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_slv_rd_ctrl.sv
// AXI4 read-channel (AR/R) slave fronting a single-port synchronous SRAM, one burst at a time.
// Define AXI_SLV_RD_ADDR_CHK_EN to return SLVERR (and skip the SRAM read) for out-of-window beats.
module axi_slv_rd_ctrl
  import axi_slv_rd_ctrl_pkg::*;
#(
  parameter logic [`AXI_ADDR_WIDTH-1:0] BASE_ADDR = `INST_MEM_BASE_ADDR,
  parameter int unsigned                MEM_AW    = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        axi_slv_arvalid,
  output logic                        axi_slv_arready,
  input  logic [`AXI_ID_WIDTH-1:0]    axi_slv_arid,
  input  logic [`AXI_ADDR_WIDTH-1:0]  axi_slv_araddr,
  input  logic [`AXI_LEN_WIDTH-1:0]   axi_slv_arlen,
  input  logic [`AXI_SIZE_WIDTH-1:0]  axi_slv_arsize,
  input  logic [`AXI_BURST_WIDTH-1:0] axi_slv_arburst,
  output logic                        axi_slv_rvalid,
  input  logic                        axi_slv_rready,
  output logic [`AXI_ID_WIDTH-1:0]    axi_slv_rid,
  output logic [`AXI_DATA_WIDTH-1:0]  axi_slv_rdata,
  output logic [`AXI_RESP_WIDTH-1:0]  axi_slv_rresp,
  output logic                        axi_slv_rlast,
  output logic                        mem_rd_en,
  output logic [MEM_AW-1:0]           mem_rd_addr,
  input  logic [`AXI_DATA_WIDTH-1:0]  mem_rd_data
);

  rd_state_e                   state_q;
  logic                        arready_q;
  logic                        rvalid_q;
  logic                        rlast_q;
  logic                        mem_rd_en_q;
  logic [`AXI_ID_WIDTH-1:0]    rid_q;
  logic [`AXI_DATA_WIDTH-1:0]  rdata_q;
  logic [`AXI_RESP_WIDTH-1:0]  rresp_q;
  logic [MEM_AW-1:0]           mem_rd_addr_q;
  logic [`AXI_ADDR_WIDTH-1:0]  cur_addr_q;
  logic [`AXI_LEN_WIDTH-1:0]   len_q;
  logic [`AXI_SIZE_WIDTH-1:0]  size_q;
  logic [`AXI_BURST_WIDTH-1:0] burst_q;
  logic [`AXI_LEN_WIDTH-1:0]   beat_cnt_q;
  logic                        burst_err_q;

  logic [`AXI_ADDR_WIDTH-1:0]  next_addr;
  logic [`AXI_ADDR_WIDTH-1:0]  launch_addr;
  logic [MEM_AW-1:0]           launch_word;
  logic                        launch_ok;
  logic                        cur_ok;
  logic                        ar_err;

  axi_burst_addr_gen u_addr_gen (
    .addr_i      (cur_addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  // The SRAM strobe is registered, so it is launched with the address of the beat about to enter RD.
  assign launch_addr = (state_q == IDLE) ? axi_slv_araddr : next_addr;
  assign launch_word = MEM_AW'((launch_addr - BASE_ADDR) >> 2);
  assign ar_err      = (axi_slv_arburst == `AXI_BURTS_RSVD) || (axi_slv_arsize > `AXI_SIZE_4B);

`ifdef AXI_SLV_RD_ADDR_CHK_EN
  assign launch_ok = in_window(launch_addr, BASE_ADDR, MEM_AW);
  assign cur_ok    = in_window(cur_addr_q, BASE_ADDR, MEM_AW);
`else
  assign launch_ok = 1'b1;
  assign cur_ok    = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rlast_q       <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      rid_q         <= '0;
      rdata_q       <= '0;
      rresp_q       <= '0;
      mem_rd_addr_q <= '0;
      cur_addr_q    <= '0;
      len_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      beat_cnt_q    <= '0;
      burst_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          arready_q <= 1'b1;
          if (axi_slv_arvalid && arready_q) begin
            arready_q     <= 1'b0;
            rid_q         <= axi_slv_arid;
            cur_addr_q    <= axi_slv_araddr;
            len_q         <= axi_slv_arlen;
            size_q        <= axi_slv_arsize;
            burst_q       <= axi_slv_arburst;
            burst_err_q   <= ar_err;
            beat_cnt_q    <= '0;
            mem_rd_en_q   <= launch_ok;
            mem_rd_addr_q <= launch_word;
            state_q       <= RD;
          end
        end
        RD: begin
          mem_rd_en_q <= 1'b0;
          rvalid_q    <= 1'b1;
          rdata_q     <= cur_ok ? mem_rd_data : '0;
          rresp_q     <= (burst_err_q || !cur_ok) ? `AXI_RESP_SLVERR : `AXI_RESP_OKAY;
          rlast_q     <= (beat_cnt_q == len_q);
          state_q     <= RESP;
        end
        RESP: begin
          if (axi_slv_rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              state_q <= IDLE;
            end else begin
              cur_addr_q    <= next_addr;
              beat_cnt_q    <= beat_cnt_q + 1'b1;
              mem_rd_en_q   <= launch_ok;
              mem_rd_addr_q <= launch_word;
              state_q       <= RD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign axi_slv_arready = arready_q;
  assign axi_slv_rvalid  = rvalid_q;
  assign axi_slv_rid     = rid_q;
  assign axi_slv_rdata   = rdata_q;
  assign axi_slv_rresp   = rresp_q;
  assign axi_slv_rlast   = rlast_q;
  assign mem_rd_en       = mem_rd_en_q;
  assign mem_rd_addr     = mem_rd_addr_q;

endmodule

// File: tb/tb_axi_slv_rd_ctrl.sv
// Scoreboard bench for axi_slv_rd_ctrl: expected R beats are queued per AR and popped on each R handshake.
module tb_axi_slv_rd_ctrl;

  localparam logic [31:0] BASE  = `INST_MEM_BASE_ADDR;
  localparam int unsigned MAW   = 12;
  localparam int unsigned WORDS = 1 << MAW;

  logic        clk;
  logic        rst_n;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        mem_rd_en;
  logic [MAW-1:0] mem_rd_addr;
  logic [31:0] mem_rd_data;

  axi_slv_rd_ctrl #(.BASE_ADDR(BASE), .MEM_AW(MAW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .axi_slv_arvalid (arvalid),
    .axi_slv_arready (arready),
    .axi_slv_arid    (arid),
    .axi_slv_araddr  (araddr),
    .axi_slv_arlen   (arlen),
    .axi_slv_arsize  (arsize),
    .axi_slv_arburst (arburst),
    .axi_slv_rvalid  (rvalid),
    .axi_slv_rready  (rready),
    .axi_slv_rid     (rid),
    .axi_slv_rdata   (rdata),
    .axi_slv_rresp   (rresp),
    .axi_slv_rlast   (rlast),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_data     (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: data for the strobed address is presented before the edge that ends the strobe.
  logic [31:0] mem [WORDS];
  assign mem_rd_data = mem_rd_en ? mem[mem_rd_addr] : 32'hBAD0_0BAD;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       sbq[$];
  int unsigned n_vec = 0, n_err = 0;
  int unsigned exp_en = 0, seen_en = 0;
  int unsigned cyc = 0, last_cyc = 0;
  int unsigned rr_mode = 0;
  logic        held;
  beat_t       held_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_addr(input logic [31:0] start, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input logic [31:0] i);
    logic [31:0] step, bound, base;
    step  = (size > 3'd2) ? 32'd4 : (32'd1 << size);
    bound = ({24'd0, len} + 32'd1) * step;
    base  = (start / bound) * bound;
    if (burst == 2'b00) return start;
    if (burst == 2'b10) return base + ((start - base + i * step) % bound);
    return start + i * step;
  endfunction

  task automatic push_burst(input logic [3:0] id, input logic [31:0] start, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a, w;
    logic        ok, err;
    beat_t       b;
    err = (burst == 2'b11) || (size > 3'd2);
    for (int unsigned i = 0; i <= 32'(len); i++) begin
      a  = model_addr(start, len, size, burst, i);
      w  = (a - BASE) >> 2;
      ok = 1'b1;
`ifdef AXI_SLV_RD_ADDR_CHK_EN
      ok = (a >= BASE) && ((a - BASE) < 4 * WORDS);
`endif
      b.id   = id;
      b.data = ok ? mem[w[MAW-1:0]] : 32'd0;
      b.resp = (err || !ok) ? 2'b10 : 2'b00;
      b.last = (i == 32'(len));
      sbq.push_back(b);
      if (ok) exp_en++;
    end
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, output int unsigned hs_cyc);
    logic got;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    push_burst(id, addr, len, size, burst);
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      if (arready) got = 1'b1;
    end
    check("ar_accept", 64'(got), 64'd1);
    hs_cyc = cyc;
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((sbq.size() != 0 || rvalid) && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check("drain", 64'(sbq.size()), 64'd0);
    check("rd_en_count", 64'(seen_en), 64'(exp_en));
  endtask

  // R-channel monitor: compares each handshake against the queue and checks stability while stalled.
  initial begin
    beat_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (mem_rd_en) seen_en++;
        if (held) begin
          check("hold_valid", 64'(rvalid), 64'd1);
          check("hold_beat", 64'({rid, rdata, rresp, rlast}), 64'(held_b));
        end
        held = 1'b0;
        if (rvalid && rready) begin
          if (sbq.size() == 0) begin
            check("spurious_beat", 64'(sbq.size()), 64'd1);
          end else begin
            e = sbq.pop_front();
            check("rid", 64'(rid), 64'(e.id));
            check("rdata", 64'(rdata), 64'(e.data));
            check("rresp", 64'(rresp), 64'(e.resp));
            check("rlast", 64'(rlast), 64'(e.last));
          end
          if (rlast) last_cyc = cyc;
        end else if (rvalid) begin
          held   = 1'b1;
          held_b = {rid, rdata, rresp, rlast};
        end
      end
    end
  end

  initial begin
    rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       rready = 1'b1;
        1:       rready = ~rready;
        default: rready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned h1, h2;
    for (int unsigned i = 0; i < WORDS; i++) mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    mem[4] = 32'hDEAD_BEEF;
    rst_n = 1'b0; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;

    repeat (3) @(negedge clk);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_zero_regs", 64'({rid, rdata, rresp, mem_rd_addr}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arready_after_rst", 64'(arready), 64'd1);

    // Single beat: latency and arready return
    rr_mode = 0;
    do_ar(4'd3, BASE + 32'h10, 8'd0, 3'd2, 2'b01, h1);
    check("lat_cycle1_rvalid", 64'(rvalid), 64'd0);
    check("lat_cycle1_arready", 64'(arready), 64'd0);
    @(posedge clk); #1;
    check("lat_cycle2_rvalid", 64'(rvalid), 64'd1);
    check("lat_rdata", 64'(rdata), 64'hDEAD_BEEF);
    @(posedge clk); #1;
    check("post_last_arready", 64'(arready), 64'd0);
    @(posedge clk); #1;
    check("arready_returns", 64'(arready), 64'd1);
    drain();

    rr_mode = 1;
    do_ar(4'd1, BASE, 8'd3, 3'd2, 2'b01, h1);                    drain();
    rr_mode = 0;
    do_ar(4'd2, BASE + 32'h08, 8'd3, 3'd2, 2'b10, h1);           drain();
    do_ar(4'd4, BASE + 32'h08, 8'd2, 3'd2, 2'b00, h1);           drain();
    do_ar(4'd7, BASE + 32'h01, 8'd4, 3'd0, 2'b01, h1);           drain();
    do_ar(4'd8, BASE + 32'h0A, 8'd7, 3'd1, 2'b10, h1);           drain();
    do_ar(4'd9, BASE + 32'h100, 8'd2, 3'd3, 2'b01, h1);          drain();
    do_ar(4'hA, BASE + 32'h60, 8'd1, 3'd2, 2'b11, h1);           drain();
    do_ar(4'hB, BASE + 4 * WORDS - 4, 8'd1, 3'd2, 2'b01, h1);    drain();

    // Back-to-back: second AR presented while the first burst is in flight
    do_ar(4'd5, BASE + 32'h20, 8'd1, 3'd2, 2'b01, h1);
    do_ar(4'd6, BASE + 32'h30, 8'd0, 3'd2, 2'b01, h2);
    check("b2b_accept_gap", 64'(h2 - last_cyc), 64'd2);
    drain();

    // Reset during beat 2 of an 8-beat burst
    do_ar(4'hC, BASE + 32'h40, 8'd7, 3'd2, 2'b01, h1);
    for (int k = 0; k < 100 && sbq.size() > 7; k++) @(negedge clk);
    check("mid_burst_reached", 64'(sbq.size()), 64'd7);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", 64'(rvalid), 64'd0);
    check("rst_mid_arready", 64'(arready), 64'd0);
    check("rst_mid_mem_rd_en", 64'(mem_rd_en), 64'd0);
    sbq.delete();
    exp_en = 0; seen_en = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_arready_back", 64'(arready), 64'd1);
    do_ar(4'hD, BASE + 32'h80, 8'd3, 3'd2, 2'b01, h1);           drain();

    // Maximum length burst under random back-pressure
    rr_mode = 2;
    do_ar(4'hE, BASE + 32'h400, 8'd255, 3'd2, 2'b01, h1);        drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
